mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and write-back select, directly downstream of the data-memory stage.
- Aligns each instruction's control and ALU result with the load data, which the memory stage returns registered one clock after the address.
- Selects the register-file write data and drives the register-file write port plus forwarding taps.
- Keeps a saturating retired-instruction counter.

Parameters:
WORD, 64, datapath width; matches `WORD.
REGBITS, 5, register index width.
ZERO_REG, 31, index of XZR; writes to it are suppressed.
CNTW, 32, retired-counter width.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high; clears all state.
in_valid  input  1  instruction present at the memory-stage inputs this cycle.
stall  input  1  hold both internal stages.
flush  input  1  invalidate both internal stages.
reg_write  input  1  instruction writes a register.
mem_to_reg  input  1  write-back source: 1 = load data, 0 = ALU result.
write_reg  input  REGBITS  destination register.
alu_result  input  WORD  ALU result, presented with the memory address.
mem_read_data  input  WORD  load data from the memory stage, valid one cycle after the address.
wb_valid  output  1  stage B holds a valid instruction.
wb_reg_write  output  1  register-file write enable.
wb_write_reg  output  REGBITS  register-file write address.
wb_write_data  output  WORD  register-file write data.
retired_count  output  CNTW  saturating count of instructions loaded into stage B.

Behaviour:
- Clock and reset: single clock, clk. reset is asynchronous and active-high.
- On reset, all state clears to 0: stage A, stage B, and the counter. As a result, every output is 0.
- Stage A (alignment register): each non-stalled edge captures in_valid, reg_write, mem_to_reg, write_reg and alu_result.
- Stage B (MEM/WB register):
  - Each non-stalled edge captures stage A's fields.
  - On the same edge it also captures the mem_read_data present during that cycle, i.e. the data for stage A's instruction.
- Latency: inputs at cycle N appear on the outputs after the edge ending cycle N+1, i.e. two edges.
- Priority: reset > flush > stall > advance.
- flush:
  - Clears the valid bits of A and B on the next edge.
  - Data fields may load but are don't-care.
  - flush and stall asserted together: flush wins.
- stall:
  - A and B hold every field.
  - mem_read_data is ignored; the memory stage is likewise frozen by its owner.
- Write-enable and data:
  - wb_reg_write = B.valid & B.reg_write & (B.write_reg != ZERO_REG). Combinational from stage B.
  - wb_write_data = B.mem_to_reg ? B.load_data : B.alu_result. Combinational from stage B.
  - wb_write_reg passes through from B unconditionally.
- During a stall, wb_reg_write stays asserted with the same data. The write is idempotent, so no one-shot behaviour is required.
- An invalid bubble must never assert wb_reg_write, whatever its reg_write field holds.
- retired_count:
  - Increments by 1 on each edge where stage B advances (not stall, not flush) and loads A.valid = 1.
  - Saturates at all-ones.
  - Not incremented while stalled or flushed.
- Counting is independent of reg_write: stores and branches count.
- Reset mid-stream: all in-flight instructions are lost, counter goes to 0, and no write occurs on the reset cycle or on the first edge after deassertion.
- Back-to-back dependence: forwarding consumers read wb_write_reg/wb_write_data/wb_reg_write directly. There is no internal bypass.

Test Plan:
- Reset, then in_valid=1, reg_write=1, mem_to_reg=0, write_reg=3, alu_result=0x10 at cycle 0 -> after the 2nd edge: wb_reg_write=1, wb_write_reg=3, wb_write_data=0x10, retired_count=1.
- Load: in cycle 0 mem_to_reg=1, write_reg=5, alu_result=0x40; mem_read_data=0xDEAD in cycle 1 only (0xFFFF in cycles 0 and 2) -> wb_write_data=0xDEAD, wb_write_reg=5.
- write_reg=31, reg_write=1, valid -> wb_reg_write=0, wb_valid=1, counter increments.
- Stream of 3 valid instructions; stall high for 2 cycles after the first edge -> outputs and counter frozen during the stall; order preserved; final retired_count=3.
- flush and stall together with 2 instructions in flight -> next cycle wb_valid=0, wb_reg_write=0, counter unchanged.
- Preload counter near all-ones (CNTW=4 override: 14 retirements, then 3 more) -> retired_count=15 and holds. Then assert reset asynchronously mid-cycle -> all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: aligns control and ALU result with registered load data,
// selects register-file write data, and keeps a saturating retired-instruction counter.
module mem_wb_stage #(
  parameter int WORD     = 64,
  parameter int REGBITS  = 5,
  parameter int ZERO_REG = 31,
  parameter int CNTW     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic               reg_write,
  input  logic               mem_to_reg,
  input  logic [REGBITS-1:0] write_reg,
  input  logic [WORD-1:0]    alu_result,
  input  logic [WORD-1:0]    mem_read_data,
  output logic               wb_valid,
  output logic               wb_reg_write,
  output logic [REGBITS-1:0] wb_write_reg,
  output logic [WORD-1:0]    wb_write_data,
  output logic [CNTW-1:0]    retired_count
);

  localparam logic [REGBITS-1:0] XZR     = REGBITS'(ZERO_REG);
  localparam logic [CNTW-1:0]    CNT_MAX = '1;

  logic               a_valid_q, a_valid_d;
  logic               a_reg_write_q, a_reg_write_d;
  logic               a_mem_to_reg_q, a_mem_to_reg_d;
  logic [REGBITS-1:0] a_write_reg_q, a_write_reg_d;
  logic [WORD-1:0]    a_alu_q, a_alu_d;

  logic               b_valid_q, b_valid_d;
  logic               b_reg_write_q, b_reg_write_d;
  logic               b_mem_to_reg_q, b_mem_to_reg_d;
  logic [REGBITS-1:0] b_write_reg_q, b_write_reg_d;
  logic [WORD-1:0]    b_alu_q, b_alu_d;
  logic [WORD-1:0]    b_load_q, b_load_d;

  logic [CNTW-1:0]    cnt_q, cnt_d;

  // Flush beats stall; on flush the data fields still load but only valid matters.
  always_comb begin
    a_valid_d      = a_valid_q;
    a_reg_write_d  = a_reg_write_q;
    a_mem_to_reg_d = a_mem_to_reg_q;
    a_write_reg_d  = a_write_reg_q;
    a_alu_d        = a_alu_q;
    b_valid_d      = b_valid_q;
    b_reg_write_d  = b_reg_write_q;
    b_mem_to_reg_d = b_mem_to_reg_q;
    b_write_reg_d  = b_write_reg_q;
    b_alu_d        = b_alu_q;
    b_load_d       = b_load_q;
    cnt_d          = cnt_q;

    if (flush || !stall) begin
      a_reg_write_d  = reg_write;
      a_mem_to_reg_d = mem_to_reg;
      a_write_reg_d  = write_reg;
      a_alu_d        = alu_result;
      b_reg_write_d  = a_reg_write_q;
      b_mem_to_reg_d = a_mem_to_reg_q;
      b_write_reg_d  = a_write_reg_q;
      b_alu_d        = a_alu_q;
      b_load_d       = mem_read_data;
    end

    if (flush) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end else if (!stall) begin
      a_valid_d = in_valid;
      b_valid_d = a_valid_q;
      if (a_valid_q && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid_q      <= 1'b0;
      a_reg_write_q  <= 1'b0;
      a_mem_to_reg_q <= 1'b0;
      a_write_reg_q  <= '0;
      a_alu_q        <= '0;
      b_valid_q      <= 1'b0;
      b_reg_write_q  <= 1'b0;
      b_mem_to_reg_q <= 1'b0;
      b_write_reg_q  <= '0;
      b_alu_q        <= '0;
      b_load_q       <= '0;
      cnt_q          <= '0;
    end else begin
      a_valid_q      <= a_valid_d;
      a_reg_write_q  <= a_reg_write_d;
      a_mem_to_reg_q <= a_mem_to_reg_d;
      a_write_reg_q  <= a_write_reg_d;
      a_alu_q        <= a_alu_d;
      b_valid_q      <= b_valid_d;
      b_reg_write_q  <= b_reg_write_d;
      b_mem_to_reg_q <= b_mem_to_reg_d;
      b_write_reg_q  <= b_write_reg_d;
      b_alu_q        <= b_alu_d;
      b_load_q       <= b_load_d;
      cnt_q          <= cnt_d;
    end
  end

  always_comb begin
    wb_valid      = b_valid_q;
    wb_reg_write  = b_valid_q && b_reg_write_q && (b_write_reg_q != XZR);
    wb_write_reg  = b_write_reg_q;
    wb_write_data = b_mem_to_reg_q ? b_load_q : b_alu_q;
    retired_count = cnt_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; a second instance with a 4-bit
// counter exercises saturation.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, stall, flush, reg_write, mem_to_reg;
  logic [4:0]  write_reg;
  logic [63:0] alu_result, mem_read_data;

  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [63:0] wb_write_data;
  logic [31:0] retired_count;

  logic        s_wb_valid, s_wb_reg_write;
  logic [4:0]  s_wb_write_reg;
  logic [63:0] s_wb_write_data;
  logic [3:0]  s_retired_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .write_reg(write_reg),
    .alu_result(alu_result), .mem_read_data(mem_read_data),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data), .retired_count(retired_count)
  );

  mem_wb_stage #(.CNTW(4)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .write_reg(write_reg),
    .alu_result(alu_result), .mem_read_data(mem_read_data),
    .wb_valid(s_wb_valid), .wb_reg_write(s_wb_reg_write), .wb_write_reg(s_wb_write_reg),
    .wb_write_data(s_wb_write_data), .retired_count(s_retired_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic rw, input logic m2r,
                               input logic [4:0] wr, input logic [63:0] alu, input logic [63:0] mem);
    in_valid      = v;
    reg_write     = rw;
    mem_to_reg    = m2r;
    write_reg     = wr;
    alu_result    = alu;
    mem_read_data = mem;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'hFFFF);
    #2;
    checkOutput("reset_valid", {63'd0, wb_valid}, 64'd0);
    checkOutput("reset_we", {63'd0, wb_reg_write}, 64'd0);
    checkOutput("reset_wr", {59'd0, wb_write_reg}, 64'd0);
    checkOutput("reset_data", wb_write_data, 64'd0);
    checkOutput("reset_cnt", {32'd0, retired_count}, 64'd0);
    step();
    step();
    reset = 1'b0;

    // ALU write-back, two-edge latency
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd3, 64'h10, 64'hFFFF);
    step();
    checkOutput("alu_latency_valid", {63'd0, wb_valid}, 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'hFFFF);
    step();
    checkOutput("alu_we", {63'd0, wb_reg_write}, 64'd1);
    checkOutput("alu_wr", {59'd0, wb_write_reg}, 64'd3);
    checkOutput("alu_data", wb_write_data, 64'h10);
    checkOutput("alu_cnt", {32'd0, retired_count}, 64'd1);

    // Load: data arrives one cycle after the address; bubble keeps reg_write=1
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd5, 64'h40, 64'hFFFF);
    step();
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd5, 64'h40, 64'hDEAD);
    step();
    checkOutput("load_data", wb_write_data, 64'hDEAD);
    checkOutput("load_wr", {59'd0, wb_write_reg}, 64'd5);
    checkOutput("load_we", {63'd0, wb_reg_write}, 64'd1);
    checkOutput("load_cnt", {32'd0, retired_count}, 64'd2);
    mem_read_data = 64'hFFFF;
    step();
    checkOutput("bubble_valid", {63'd0, wb_valid}, 64'd0);
    checkOutput("bubble_we", {63'd0, wb_reg_write}, 64'd0);
    checkOutput("bubble_cnt", {32'd0, retired_count}, 64'd2);

    // XZR destination: counted but not written
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd31, 64'h77, 64'hFFFF);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'hFFFF);
    step();
    checkOutput("xzr_valid", {63'd0, wb_valid}, 64'd1);
    checkOutput("xzr_we", {63'd0, wb_reg_write}, 64'd0);
    checkOutput("xzr_cnt", {32'd0, retired_count}, 64'd3);

    // Stream of three with a 2-cycle stall after the first edge
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd1, 64'h101, 64'hFFFF);
    step();
    checkOutput("stream_e1_cnt", {32'd0, retired_count}, 64'd3);
    stall = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd2, 64'h102, 64'hBAD);
    step();
    checkOutput("stall1_valid", {63'd0, wb_valid}, 64'd0);
    checkOutput("stall1_cnt", {32'd0, retired_count}, 64'd3);
    step();
    checkOutput("stall2_valid", {63'd0, wb_valid}, 64'd0);
    checkOutput("stall2_cnt", {32'd0, retired_count}, 64'd3);
    stall = 1'b0;
    step();
    checkOutput("i1_wr", {59'd0, wb_write_reg}, 64'd1);
    checkOutput("i1_data", wb_write_data, 64'h101);
    checkOutput("i1_cnt", {32'd0, retired_count}, 64'd4);
    stall = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd3, 64'h103, 64'hBAD);
    step();
    checkOutput("stall_hold_we", {63'd0, wb_reg_write}, 64'd1);
    checkOutput("stall_hold_wr", {59'd0, wb_write_reg}, 64'd1);
    checkOutput("stall_hold_data", wb_write_data, 64'h101);
    checkOutput("stall_hold_cnt", {32'd0, retired_count}, 64'd4);
    stall = 1'b0;
    step();
    checkOutput("i2_wr", {59'd0, wb_write_reg}, 64'd2);
    checkOutput("i2_data", wb_write_data, 64'h102);
    checkOutput("i2_cnt", {32'd0, retired_count}, 64'd5);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'hFFFF);
    step();
    checkOutput("i3_wr", {59'd0, wb_write_reg}, 64'd3);
    checkOutput("i3_data", wb_write_data, 64'h103);
    checkOutput("i3_cnt", {32'd0, retired_count}, 64'd6);

    // flush together with stall, two instructions in flight
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd7, 64'h7, 64'hFFFF);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd8, 64'h8, 64'hFFFF);
    step();
    checkOutput("pre_flush_wr", {59'd0, wb_write_reg}, 64'd7);
    checkOutput("pre_flush_cnt", {32'd0, retired_count}, 64'd7);
    flush = 1'b1;
    stall = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'hFFFF);
    step();
    checkOutput("flush_valid", {63'd0, wb_valid}, 64'd0);
    checkOutput("flush_we", {63'd0, wb_reg_write}, 64'd0);
    checkOutput("flush_cnt", {32'd0, retired_count}, 64'd7);
    flush = 1'b0;
    stall = 1'b0;
    step();
    checkOutput("post_flush_valid", {63'd0, wb_valid}, 64'd0);
    checkOutput("post_flush_cnt", {32'd0, retired_count}, 64'd7);

    // Saturation on the 4-bit counter instance
    reset = 1'b1;
    step();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd9, 64'h99, 64'hFFFF);
    for (int i = 0; i < 15; i++) step();
    checkOutput("sat_14", {60'd0, s_retired_count}, 64'd14);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("sat_hold", {60'd0, s_retired_count}, 64'd15);
    end
    checkOutput("wide_cnt_17", {32'd0, retired_count}, 64'd17);
    checkOutput("pre_async_we", {63'd0, wb_reg_write}, 64'd1);

    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_valid", {63'd0, wb_valid}, 64'd0);
    checkOutput("async_we", {63'd0, wb_reg_write}, 64'd0);
    checkOutput("async_data", wb_write_data, 64'd0);
    checkOutput("async_cnt", {32'd0, retired_count}, 64'd0);
    checkOutput("async_sat_cnt", {60'd0, s_retired_count}, 64'd0);
    step();
    reset = 1'b0;
    step();
    checkOutput("post_reset_we", {63'd0, wb_reg_write}, 64'd0);
    checkOutput("post_reset_cnt", {32'd0, retired_count}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
